// File: rtl/ff_processor_set.sv
// ============================================================================
// ff_processor_set : z/fi fan-in-fi neurons, dot product -> PLAN sigmoid + prime
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module ff_processor_set #(
  parameter int fo        = 2,
  parameter int fi        = 4,
  parameter int p         = 8,
  parameter int n         = 4,
  parameter int z         = 4,
  parameter int width     = 16,
  parameter int int_bits  = 5,
  parameter int frac_bits = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [width*z-1:0]      a_package,
  input  logic [width*z-1:0]      w_package,
  output logic [width*z/fi-1:0]   sigmoid_package,
  output logic [width*z/fi-1:0]   sp_package
);

  localparam int nproc = z / fi;
  localparam int acc_w = width + frac_bits + $clog2(fi);

  localparam logic signed [acc_w-1:0] sat_pos = acc_w'((2**(width-1)) - 1);
  localparam logic signed [acc_w-1:0] sat_neg = -sat_pos;

  localparam logic [width-1:0] one_c   = width'(1 << frac_bits);
  localparam logic [width-1:0] th_5    = width'(5 << frac_bits);
  localparam logic [width-1:0] th_2375 = width'(19 << (frac_bits - 3));
  localparam logic [width-1:0] off_hi  = width'(27 << (frac_bits - 5));
  localparam logic [width-1:0] off_mid = width'(5 << (frac_bits - 3));
  localparam logic [width-1:0] off_lo  = width'(1 << (frac_bits - 1));

  // Layer-shape parameters only document the surrounding network.
  if (fo < 1 || p < 1 || n < 1 || width != 1 + int_bits + frac_bits) begin : g_cfg_note
  end

  // Stage-1 validity: keeps outputs at 0 until the first post-reset result.
  logic v1_q;
  logic v1_d;

  always_comb begin
    v1_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) v1_q <= 1'b0;
    else        v1_q <= v1_d;
  end

  for (genvar j = 0; j < nproc; j++) begin : g_proc
    logic signed [acc_w-1:0]   sum;
    logic        [width-1:0]   x_d, x_q;
    logic        [width-1:0]   m, y, s;
    logic        [2*width-1:0] prod_s;
    logic        [width-1:0]   sig_d, sig_q, sp_d, sp_q;

    always_comb begin
      logic signed [2*width-1:0] prod;
      sum  = '0;
      prod = '0;
      for (int k = 0; k < fi; k++) begin
        prod = $signed(a_package[width*(j*fi+k) +: width]) *
               $signed(w_package[width*(j*fi+k) +: width]);
        sum  = sum + acc_w'(prod >>> frac_bits);
      end
      if (sum > sat_pos)      x_d = sat_pos[width-1:0];
      else if (sum < sat_neg) x_d = sat_neg[width-1:0];
      else                    x_d = sum[width-1:0];
    end

    always_comb begin
      m = x_q[width-1] ? (~x_q + 1'b1) : x_q;
      if (m >= th_5)         y = one_c;
      else if (m >= th_2375) y = (m >> 5) + off_hi;
      else if (m >= one_c)   y = (m >> 3) + off_mid;
      else                   y = (m >> 2) + off_lo;
      s      = x_q[width-1] ? (one_c - y) : y;
      prod_s = {{width{1'b0}}, s} * {{width{1'b0}}, (one_c - s)};
      sig_d  = v1_q ? s : '0;
      sp_d   = v1_q ? prod_s[frac_bits +: width] : '0;
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        x_q   <= '0;
        sig_q <= '0;
        sp_q  <= '0;
      end else begin
        x_q   <= x_d;
        sig_q <= sig_d;
        sp_q  <= sp_d;
      end
    end

    assign sigmoid_package[width*j +: width] = sig_q;
    assign sp_package[width*j +: width]      = sp_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_ff_processor_set.sv
// ============================================================================
// tb_ff_processor_set : directed-vector bench for ff_processor_set
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ff_processor_set;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] a_package, w_package;
  logic [15:0] sigmoid_package, sp_package;

  int checks = 0;
  int errors = 0;

  ff_processor_set dut (
    .clk             (clk),
    .reset           (reset),
    .a_package       (a_package),
    .w_package       (w_package),
    .sigmoid_package (sigmoid_package),
    .sp_package      (sp_package)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int es, input int esp);
    check_eq({tag, "_sig"}, {16'd0, sigmoid_package}, 32'(es));
    check_eq({tag, "_sp"},  {16'd0, sp_package},      32'(esp));
  endtask

  // Independent integer model of one neuron.
  task automatic ref_model(input logic [63:0] a, input logic [63:0] w,
                           output int es, output int esp);
    longint acc, pr, x, m, y;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      pr  = longint'($signed(a[16*k +: 16])) * longint'($signed(w[16*k +: 16]));
      acc = acc + (pr >>> 10);
    end
    x = (acc > 32767) ? 32767 : (acc < -32767) ? -32767 : acc;
    m = (x < 0) ? -x : x;
    if (m >= 5120)      y = 1024;
    else if (m >= 2432) y = m / 32 + 864;
    else if (m >= 1024) y = m / 8 + 640;
    else                y = m / 4 + 512;
    es  = int'((x < 0) ? 1024 - y : y);
    esp = (es * (1024 - es)) / 1024;
  endtask

  // Directed vectors: zero, +4096, -4096, small, saturating.
  logic [63:0] va [5];
  logic [63:0] vw [5];
  int          vs [5] = '{512, 992, 32, 640, 1024};
  int          vp [5] = '{256, 31, 31, 240, 0};
  int          seq [8] = '{1, 2, 3, 4, 0, 2, 1, 3};

  task automatic apply(input int i);
    a_package = va[i];
    w_package = vw[i];
  endtask

  initial begin
    va[0] = 64'd0;                 vw[0] = 64'd0;
    va[1] = {4{16'd1024}};         vw[1] = {4{16'd1024}};
    va[2] = {4{16'd1024}};         vw[2] = {4{16'hFC00}};
    va[3] = {48'd0, 16'd512};      vw[3] = {48'd0, 16'd1024};
    va[4] = {4{16'd8192}};         vw[4] = {4{16'd8192}};

    reset = 1'b0;
    a_package = {$urandom, $urandom};
    w_package = {$urandom, $urandom};
    #1;
    for (int c = 0; c < 3; c++) begin
      step();
      a_package = {$urandom, $urandom};
      w_package = {$urandom, $urandom};
    end
    check_out("reset_hold", 0, 0);

    reset = 1'b1;
    apply(0);
    step();
    check_out("release_1", 0, 0);
    step();
    check_out("release_2", 512, 256);

    for (int i = 1; i < 5; i++) begin
      apply(i);
      step();
      step();
      check_out($sformatf("vec%0d", i), vs[i], vp[i]);
    end

    for (int j = 0; j < 9; j++) begin
      if (j < 8) apply(seq[j]);
      step();
      if (j >= 1) check_out($sformatf("pipe%0d", j - 1), vs[seq[j-1]], vp[seq[j-1]]);
    end

    apply(1);
    step();
    apply(2);
    step();
    check_out("pre_rst", 992, 31);
    reset = 1'b0;
    apply(3);
    step();
    check_out("mid_rst_1", 0, 0);
    reset = 1'b1;
    apply(4);
    step();
    check_out("mid_rst_2", 0, 0);
    apply(1);
    step();
    check_out("resume_1", 1024, 0);
    step();
    check_out("resume_2", 992, 31);

    begin
      int es_h [3];
      int ep_h [3];
      for (int j = 0; j < 40; j++) begin
        for (int k = 0; k < 4; k++) begin
          a_package[16*k +: 16] = 16'($urandom_range(0, 4095)) - 16'd2048;
          w_package[16*k +: 16] = 16'($urandom_range(0, 4095)) - 16'd2048;
        end
        ref_model(a_package, w_package, es_h[j % 3], ep_h[j % 3]);
        step();
        if (j >= 1) check_out($sformatf("rand%0d", j - 1), es_h[(j-1) % 3], ep_h[(j-1) % 3]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
